// File: rtl/debug_access_ctrl_if.sv
// Signal bundle between the debug host, the datapath snoop registers and debug_access_ctrl.
interface debug_access_ctrl_if #(parameter int NUM_REGS = 4) ();
  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic                    prod_mode;
  logic                    unlock_req;
  logic [15:0]             unlock_key;
  logic                    relock;
  logic                    rd_req;
  logic [AW-1:0]           rd_addr;
  logic [8*NUM_REGS-1:0]   snap_data;
  logic                    debug_enable;
  logic                    rd_ack;
  logic [7:0]              rd_data;
  logic                    rd_err;
  logic [1:0]              fail_cnt;
  logic [1:0]              state;

  modport master (
    output prod_mode, unlock_req, unlock_key, relock, rd_req, rd_addr, snap_data,
    input  debug_enable, rd_ack, rd_data, rd_err, fail_cnt, state
  );
  modport slave (
    input  prod_mode, unlock_req, unlock_key, relock, rd_req, rd_addr, snap_data,
    output debug_enable, rd_ack, rd_data, rd_err, fail_cnt, state
  );
endinterface

// File: rtl/debug_access_ctrl.sv
// Key-checked unlock sequencer for the debug snoop path: lockout after repeated
// bad keys, idle session timeout, and a req/ack read port gated by the session.
module debug_access_ctrl #(
  parameter logic [15:0] KEY            = 16'hC3A5,
  parameter int          MAX_ATTEMPTS   = 3,
  parameter int          LOCKOUT_CYCLES = 64,
  parameter int          SESSION_CYCLES = 256,
  parameter int          NUM_REGS       = 4
) (
  input logic clk,
  input logic rst,
  debug_access_ctrl_if.slave bus
);
  localparam int AW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int TMAX = (LOCKOUT_CYCLES > SESSION_CYCLES) ? LOCKOUT_CYCLES : SESSION_CYCLES;
  localparam int TW   = $clog2(TMAX);
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] SESS_LOAD = TW'(SESSION_CYCLES - 1);
  localparam logic [1:0]    MAX_FAIL  = 2'(MAX_ATTEMPTS);

  typedef enum logic [1:0] {LOCKED = 2'd0, CHECK = 2'd1, UNLOCKED = 2'd2, LOCKOUT = 2'd3} state_t;

  state_t          state_q, state_n;
  logic [TW-1:0]   timer_q, timer_n;
  logic [1:0]      fail_q, fail_n, fail_inc;
  logic [15:0]     key_q, key_n;
  logic            ack_q, err_q;
  logic [7:0]      data_q;
  logic [AW-1:0]   addr;
  logic            kill, rd_accept, rd_ok;

  assign addr      = bus.rd_addr;
  assign kill      = bus.relock | bus.prod_mode;
  // The pending ack doubles as the busy flag, so a held rd_req accepts every other cycle.
  assign rd_accept = bus.rd_req & ~ack_q;
  assign rd_ok     = (state_q == UNLOCKED) & ~kill;
  assign fail_inc  = fail_q + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOCKED;
      timer_q <= '0;
      fail_q  <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_n;
      timer_q <= timer_n;
      fail_q  <= fail_n;
      key_q   <= key_n;
    end
  end

  always_comb begin
    state_n = state_q;
    timer_n = timer_q;
    fail_n  = fail_q;
    key_n   = key_q;
    case (state_q)
      LOCKED: begin
        if (bus.unlock_req && !bus.prod_mode) begin
          key_n   = bus.unlock_key;
          state_n = CHECK;
        end
      end
      CHECK: begin
        // Captured key is single-use; scrub it whatever the outcome.
        key_n = '0;
        if (key_q == KEY) begin
          state_n = UNLOCKED;
          fail_n  = '0;
          timer_n = SESS_LOAD;
        end else begin
          fail_n = fail_inc;
          if (fail_inc == MAX_FAIL) begin
            state_n = LOCKOUT;
            timer_n = LOCK_LOAD;
          end else begin
            state_n = LOCKED;
          end
        end
      end
      LOCKOUT: begin
        if (timer_q == '0) begin
          state_n = LOCKED;
          fail_n  = '0;
        end else begin
          timer_n = timer_q - 1'b1;
        end
      end
      UNLOCKED: begin
        if (kill) begin
          state_n = LOCKED;
          timer_n = '0;
        end else if (rd_accept) begin
          timer_n = SESS_LOAD;
        end else if (timer_q == '0) begin
          state_n = LOCKED;
        end else begin
          timer_n = timer_q - 1'b1;
        end
      end
      default: state_n = LOCKED;
    endcase
  end

  // Read response is decided from the accept-cycle state and sampled snap data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q  <= 1'b0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      ack_q  <= rd_accept;
      data_q <= (rd_accept && rd_ok) ? bus.snap_data[{addr, 3'b000} +: 8] : 8'h00;
      err_q  <= rd_accept & ~rd_ok;
    end
  end

  assign bus.debug_enable = (state_q == UNLOCKED);
  assign bus.rd_ack       = ack_q;
  assign bus.rd_data      = data_q;
  assign bus.rd_err       = err_q;
  assign bus.fail_cnt     = fail_q;
  assign bus.state        = state_q;
endmodule

// File: tb/tb_debug_access_ctrl.sv
// Scenario and randomized bench for debug_access_ctrl against a cycle-counting model.
module tb_debug_access_ctrl;
  localparam logic [15:0] KEY = 16'hC3A5;
  localparam int MAXA = 3, LOCKC = 64, SESSC = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  debug_access_ctrl_if #(.NUM_REGS(4)) bus ();
  debug_access_ctrl #(.KEY(KEY), .MAX_ATTEMPTS(MAXA), .LOCKOUT_CYCLES(LOCKC),
                      .SESSION_CYCLES(SESSC), .NUM_REGS(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0, passed = 0;

  // Model: phase 0 locked, 1 check, 2 unlocked, 3 lockout; counters count elapsed cycles.
  int m_state, m_fail, m_idle, m_spent;
  logic [15:0] m_key;
  logic m_ack, m_err;
  logic [7:0] m_data;

  task automatic model_reset();
    m_state = 0; m_fail = 0; m_idle = 0; m_spent = 0; m_key = '0;
    m_ack = 0; m_err = 0; m_data = '0;
  endtask

  task automatic model_step();
    logic accept, ok;
    logic [31:0] snap;
    snap   = bus.snap_data;
    accept = bus.rd_req && !m_ack;
    ok     = (m_state == 2) && !bus.relock && !bus.prod_mode;
    m_ack  = accept;
    m_err  = accept && !ok;
    m_data = (accept && ok) ? snap[8*bus.rd_addr +: 8] : 8'h00;
    case (m_state)
      0: if (bus.unlock_req && !bus.prod_mode) begin m_key = bus.unlock_key; m_state = 1; end
      1: if (m_key == KEY) begin m_state = 2; m_fail = 0; m_idle = 0; end
         else begin
           m_fail++;
           if (m_fail == MAXA) begin m_state = 3; m_spent = 0; end else m_state = 0;
         end
      3: begin m_spent++; if (m_spent == LOCKC) begin m_state = 0; m_fail = 0; end end
      default: begin
        if (bus.relock || bus.prod_mode) m_state = 0;
        else if (accept) m_idle = 0;
        else begin m_idle++; if (m_idle == SESSC) m_state = 0; end
      end
    endcase
  endtask

  function automatic logic [14:0] dut_vec();
    return {bus.state, bus.debug_enable, bus.fail_cnt, bus.rd_ack, bus.rd_data, bus.rd_err};
  endfunction
  function automatic logic [14:0] model_vec();
    return {2'(m_state), m_state == 2, 2'(m_fail), m_ack, m_data, m_err};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    bus.prod_mode = 0; bus.unlock_req = 0; bus.unlock_key = '0; bus.relock = 0;
    bus.rd_req = 0; bus.rd_addr = '0;
  endtask

  task automatic do_unlock(input logic [15:0] k);
    bus.unlock_req = 1; bus.unlock_key = k;
    tick();
    bus.unlock_req = 0; bus.unlock_key = '0;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.snap_data = '0;
    rst = 1; #12; model_reset();
    checks++;
    if (dut_vec() !== 15'h0) $display("FAIL reset_outputs got %h want %h", dut_vec(), 15'h0);
    else passed++;
    @(negedge clk); rst = 0;
  endtask

  task automatic test_unlock();
    bus.unlock_req = 1; bus.unlock_key = KEY;
    tick();
    bus.unlock_req = 0;
    checks++;
    if (bus.state !== 2'd1) $display("FAIL unlock_check_state got %0d want 1", bus.state);
    else passed++;
    tick();
    checks++;
    if ({bus.state, bus.debug_enable, bus.fail_cnt} !== {2'd2, 1'b1, 2'd0})
      $display("FAIL unlock_done got st=%0d en=%0d fc=%0d want st=2 en=1 fc=0",
               bus.state, bus.debug_enable, bus.fail_cnt);
    else passed++;
  endtask

  task automatic test_read();
    bus.snap_data = 32'h44332211; bus.rd_addr = 2'd2; bus.rd_req = 1;
    tick();
    bus.rd_req = 0;
    checks++;
    if ({bus.rd_ack, bus.rd_data, bus.rd_err} !== {1'b1, 8'h33, 1'b0})
      $display("FAIL read_unlocked got ack=%0d data=%h err=%0d want ack=1 data=33 err=0",
               bus.rd_ack, bus.rd_data, bus.rd_err);
    else passed++;
    tick();
    checks++;
    if ({bus.rd_ack, bus.rd_data, bus.rd_err} !== 10'h0)
      $display("FAIL read_ack_clear got ack=%0d data=%h err=%0d want 0", bus.rd_ack, bus.rd_data, bus.rd_err);
    else passed++;
    bus.relock = 1; tick(); bus.relock = 0;
    bus.rd_req = 1; tick(); bus.rd_req = 0;
    checks++;
    if ({bus.rd_ack, bus.rd_data, bus.rd_err} !== {1'b1, 8'h00, 1'b1})
      $display("FAIL read_locked got ack=%0d data=%h err=%0d want ack=1 data=00 err=1",
               bus.rd_ack, bus.rd_data, bus.rd_err);
    else passed++;
    tick();
    // Held rd_req: accepts land on alternate cycles.
    bus.rd_req = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (bus.rd_ack !== 1'(~i[0]) || dut_vec() !== model_vec())
        $display("FAIL read_held_c%0d got ack=%0d vec=%h want ack=%0d vec=%h",
                 i, bus.rd_ack, dut_vec(), ~i[0], model_vec());
      else passed++;
    end
    bus.rd_req = 0; tick();
  endtask

  task automatic test_relock_prod();
    do_unlock(KEY);
    bus.relock = 1; bus.rd_req = 1; bus.rd_addr = 2'd1;
    tick();
    bus.relock = 0; bus.rd_req = 0;
    checks++;
    if ({bus.state, bus.rd_ack, bus.rd_data, bus.rd_err} !== {2'd0, 1'b1, 8'h00, 1'b1})
      $display("FAIL relock_read got st=%0d ack=%0d data=%h err=%0d want st=0 ack=1 data=00 err=1",
               bus.state, bus.rd_ack, bus.rd_data, bus.rd_err);
    else passed++;
    bus.prod_mode = 1; bus.unlock_req = 1; bus.unlock_key = KEY;
    tick();
    bus.unlock_req = 0;
    tick();
    checks++;
    if ({bus.state, bus.fail_cnt, bus.debug_enable} !== 5'h0)
      $display("FAIL prod_unlock got st=%0d fc=%0d en=%0d want 0/0/0", bus.state, bus.fail_cnt, bus.debug_enable);
    else passed++;
    bus.prod_mode = 0;
  endtask

  task automatic test_lockout();
    for (int a = 1; a <= 3; a++) begin
      do_unlock(16'h0000);
      checks++;
      if ({bus.state, bus.fail_cnt} !== {(a == 3) ? 2'd3 : 2'd0, 2'(a)})
        $display("FAIL lockout_attempt%0d got st=%0d fc=%0d want st=%0d fc=%0d",
                 a, bus.state, bus.fail_cnt, (a == 3) ? 3 : 0, a);
      else passed++;
    end
    bus.unlock_req = 1; bus.unlock_key = KEY; tick(); bus.unlock_req = 0;
    for (int i = 0; i < 62; i++) begin
      tick();
      checks++;
      if (bus.state !== 2'd3 || dut_vec() !== model_vec())
        $display("FAIL lockout_hold_c%0d got %h want %h", i, dut_vec(), model_vec());
      else passed++;
    end
    tick();
    checks++;
    if ({bus.state, bus.fail_cnt} !== 4'h0)
      $display("FAIL lockout_exit got st=%0d fc=%0d want 0/0", bus.state, bus.fail_cnt);
    else passed++;
    do_unlock(KEY);
    checks++;
    if (bus.state !== 2'd2) $display("FAIL lockout_reunlock got st=%0d want 2", bus.state);
    else passed++;
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 255; i++) tick();
    checks++;
    if (bus.state !== 2'd2 || dut_vec() !== model_vec())
      $display("FAIL timeout_before got st=%0d vec=%h want st=2 vec=%h", bus.state, dut_vec(), model_vec());
    else passed++;
    tick();
    checks++;
    if ({bus.state, bus.debug_enable} !== 3'b000)
      $display("FAIL timeout_expire got st=%0d en=%0d want 0/0", bus.state, bus.debug_enable);
    else passed++;
    do_unlock(KEY);
    for (int i = 0; i < 199; i++) tick();
    bus.rd_req = 1; tick(); bus.rd_req = 0;
    for (int i = 0; i < 255; i++) tick();
    checks++;
    if (bus.state !== 2'd2) $display("FAIL timeout_extended got st=%0d want 2", bus.state);
    else passed++;
    tick();
    checks++;
    if (bus.state !== 2'd0 || dut_vec() !== model_vec())
      $display("FAIL timeout_after_read got st=%0d vec=%h want st=0 vec=%h", bus.state, dut_vec(), model_vec());
    else passed++;
  endtask

  task automatic test_async_reset();
    do_unlock(KEY);
    bus.rd_req = 1; tick(); bus.rd_req = 0;
    #2 rst = 1;
    #1;
    checks++;
    if ({bus.debug_enable, bus.state, bus.rd_ack} !== 4'h0)
      $display("FAIL async_reset got en=%0d st=%0d ack=%0d want 0/0/0", bus.debug_enable, bus.state, bus.rd_ack);
    else passed++;
    model_reset();
    #2 rst = 0;
    bus.rd_req = 1; tick(); bus.rd_req = 0;
    checks++;
    if ({bus.rd_ack, bus.rd_data, bus.rd_err} !== {1'b1, 8'h00, 1'b1})
      $display("FAIL post_reset_read got ack=%0d data=%h err=%0d want 1/00/1", bus.rd_ack, bus.rd_data, bus.rd_err);
    else passed++;
    tick();
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 3000; i++) begin
      bus.unlock_req = ($urandom_range(0, 5) == 0);
      bus.unlock_key = $urandom_range(0, 1) ? KEY : 16'($urandom);
      bus.relock     = ($urandom_range(0, 60) == 0);
      bus.prod_mode  = ($urandom_range(0, 90) == 0);
      bus.rd_req     = ($urandom_range(0, 2) == 0);
      bus.rd_addr    = 2'($urandom);
      bus.snap_data  = $urandom;
      tick();
      checks++;
      if (dut_vec() !== model_vec()) begin
        bad++;
        if (bad <= 10) $display("FAIL random_c%0d got %h want %h", i, dut_vec(), model_vec());
      end else passed++;
    end
    idle_inputs();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_unlock();
    test_read();
    test_relock_prod();
    test_lockout();
    test_timeout();
    test_async_reset();
    test_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
